// File: rtl/demux_1a4.sv
// Registered 1-to-4 write-back demultiplexer: a one-entry buffer routes each word
// to the register file, memory write port or output port; destination 3 is discarded and counted.
module demux_1a4 #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       ctrl,
    input  logic [WIDTH-1:0] entrada,
    input  logic             ent_valida,
    output logic             ent_lista,
    output logic [WIDTH-1:0] salida1,
    output logic [WIDTH-1:0] salida2,
    output logic [WIDTH-1:0] salida3,
    output logic             sal_valida1,
    output logic             sal_valida2,
    output logic             sal_valida3,
    input  logic             sal_lista1,
    input  logic             sal_lista2,
    input  logic             sal_lista3,
    output logic [CNT_W-1:0] descartes,
    output logic             error,
    output logic             estado_dbg
);

    // Handshake: a word moves on any side exactly when valid and ready are both high at a
    // rising edge; valid never drops and the payload never changes while waiting for ready.
    typedef enum logic {VACIO = 1'b0, LLENO = 1'b1} estado_t;

    estado_t          estado, estado_d;
    logic [WIDTH-1:0] dato, dato_d;
    logic [1:0]       dest, dest_d;
    logic             sel_lista;
    logic             acepta;
    logic             sale;
    logic             descarta;

    always_comb begin
        case (dest)
            2'd0:    sel_lista = sal_lista1;
            2'd1:    sel_lista = sal_lista2;
            default: sel_lista = sal_lista3;
        endcase
    end

    // Ready passes straight through from the active consumer so the buffer can refill
    // in the same cycle it drains.
    assign ent_lista = !rst && (estado == VACIO || sel_lista);
    assign acepta    = ent_valida && ent_lista;
    assign sale      = (estado == LLENO) && sel_lista;

    always_comb begin
        estado_d = estado;
        dato_d   = dato;
        dest_d   = dest;
        descarta = 1'b0;
        if (estado == VACIO || sale) begin
            estado_d = VACIO;
            if (acepta) begin
                if (ctrl == 2'd3) begin
                    descarta = 1'b1;
                end else begin
                    estado_d = LLENO;
                    dato_d   = entrada;
                    dest_d   = ctrl;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado    <= VACIO;
            dato      <= '0;
            dest      <= 2'd0;
            descartes <= '0;
            error     <= 1'b0;
        end else begin
            estado <= estado_d;
            dato   <= dato_d;
            dest   <= dest_d;
            error  <= descarta;
            if (descarta && descartes != {CNT_W{1'b1}})
                descartes <= descartes + 1'b1;
        end
    end

    assign salida1     = dato;
    assign salida2     = dato;
    assign salida3     = dato;
    assign sal_valida1 = (estado == LLENO) && (dest == 2'd0);
    assign sal_valida2 = (estado == LLENO) && (dest == 2'd1);
    assign sal_valida3 = (estado == LLENO) && (dest == 2'd2);
    assign estado_dbg  = estado;

endmodule
